axis_fifo: RTL and testbench

- Synchronous AXI-Stream FIFO. It buffers beats between an AXIS_IF Receiver port (upstream producer) and an AXIS_IF Transmitter port (downstream consumer, e.g. a MAC TX path).
- It has two modes:
  - Stream mode: plain backpressured buffering.
  - Packet mode: a frame is released downstream only after its tlast beat is stored. Oversized frames are dropped, and so are bad frames (tuser[0] set on tlast) when enabled.
- It sits between Ethernet framing stages and absorbs rate mismatch.

---
 rtl/axis_fifo_pkg.sv | 14 +
 rtl/axis_if.sv | 32 +++
 rtl/sdp_ram.sv | 36 +++
 rtl/axis_fifo.sv | 197 +++++++++++++++++++
 tb/tb_axis_fifo.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_fifo_pkg.sv
// Shared types and helpers for the AXI-Stream FIFO.
// Pointer width carries one extra wrap bit beyond the RAM address.
package axis_fifo_pkg;

  typedef enum logic [0:0] {
    WR_NORMAL = 1'b0,
    WR_DROP   = 1'b1
  } wr_state_t;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream interface bundle with producer and consumer views.
// twakeup is only driven by the transmitter side.
interface AXIS_IF #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
);

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic [KEEP_WIDTH-1:0] tstrb;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;
  logic                  twakeup;

  modport Transmitter (
    output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, twakeup,
    input  tready
  );

  modport Receiver (
    input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    output tready
  );

endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read data holds its value while rd_en is low so a stalled beat survives.
module sdp_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rd_data_r;

  // storage write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // registered read port, held when not reading
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/axis_fifo.sv
// AXI-Stream FIFO with optional store-and-forward frame mode.
// Read path: RAM registered read stage followed by an output register.
module axis_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DEPTH          = 512,
  parameter bit PACKET_MODE    = 1'b0,
  parameter bit DROP_BAD_FRAME = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  AXIS_IF.Receiver                    s_axis,
  AXIS_IF.Transmitter                 m_axis,
  output logic [ptr_width(DEPTH)-1:0] status_occupancy,
  output logic                        status_overflow,
  output logic                        status_bad_frame,
  output logic                        status_good_frame
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam int DW = $bits(s_axis.tdata);
  localparam int KW = $bits(s_axis.tkeep);
  localparam int IW = $bits(s_axis.tid);
  localparam int TW = $bits(s_axis.tdest);
  localparam int UW = $bits(s_axis.tuser);
  localparam int BW = DW + 2 * KW + 1 + IW + TW + UW;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  logic [PW-1:0] wr_ptr_cur_r;
  logic [PW-1:0] wr_ptr_commit_r;
  logic [PW-1:0] rd_ptr_r;
  wr_state_t     wr_state_r;
  logic          overflow_r;
  logic          bad_frame_r;
  logic          good_frame_r;
  logic          rd_pend_r;
  logic          out_valid_r;
  logic [BW-1:0] out_beat_r;

  logic [PW-1:0] wr_ptr_cur_nxt_s;
  logic [PW-1:0] wr_ptr_commit_nxt_s;
  wr_state_t     wr_state_nxt_s;
  logic          overflow_nxt_s;
  logic          bad_frame_nxt_s;
  logic          good_frame_nxt_s;
  logic          wr_en_s;
  logic          full_s;
  logic          empty_s;
  logic          s_ready_s;
  logic          accept_s;
  logic          out_ready_s;
  logic          rd_en_s;
  logic [BW-1:0] wr_beat_s;
  logic [BW-1:0] rd_beat_s;

  assign full_s  = (wr_ptr_cur_r - rd_ptr_r) == DEPTH_P;
  assign empty_s = (wr_ptr_commit_r == rd_ptr_r);

  // frame mode never backpressures; stream mode stalls only on a full RAM
  assign s_ready_s = PACKET_MODE ? !rst : (!rst && !full_s);
  assign accept_s  = s_axis.tvalid && s_ready_s;
  assign s_axis.tready = s_ready_s;

  assign wr_beat_s = {s_axis.tdata, s_axis.tkeep, s_axis.tstrb, s_axis.tlast,
                      s_axis.tid, s_axis.tdest, s_axis.tuser};

  // write-side next state: pointer updates, frame commit/drop decisions
  always_comb begin
    wr_ptr_cur_nxt_s    = wr_ptr_cur_r;
    wr_ptr_commit_nxt_s = wr_ptr_commit_r;
    wr_state_nxt_s      = wr_state_r;
    overflow_nxt_s      = 1'b0;
    bad_frame_nxt_s     = 1'b0;
    good_frame_nxt_s    = 1'b0;
    wr_en_s             = 1'b0;
    if (accept_s) begin
      if (!PACKET_MODE) begin
        wr_en_s             = 1'b1;
        wr_ptr_cur_nxt_s    = wr_ptr_cur_r + ONE_P;
        wr_ptr_commit_nxt_s = wr_ptr_cur_r + ONE_P;
      end else begin
        case (wr_state_r)
          WR_NORMAL: begin
            if (!full_s) begin
              wr_en_s          = 1'b1;
              wr_ptr_cur_nxt_s = wr_ptr_cur_r + ONE_P;
              if (s_axis.tlast) begin
                if (DROP_BAD_FRAME && s_axis.tuser[0]) begin
                  wr_ptr_cur_nxt_s = wr_ptr_commit_r;
                  bad_frame_nxt_s  = 1'b1;
                end else begin
                  wr_ptr_commit_nxt_s = wr_ptr_cur_r + ONE_P;
                  good_frame_nxt_s    = 1'b1;
                end
              end else begin
                wr_ptr_commit_nxt_s = wr_ptr_commit_r;
              end
            end else begin
              // rewinding to the commit point discards only the open frame
              wr_ptr_cur_nxt_s = wr_ptr_commit_r;
              overflow_nxt_s   = 1'b1;
              wr_state_nxt_s   = s_axis.tlast ? WR_NORMAL : WR_DROP;
            end
          end
          WR_DROP: begin
            wr_state_nxt_s = s_axis.tlast ? WR_NORMAL : WR_DROP;
          end
          default: begin
            wr_state_nxt_s = WR_NORMAL;
          end
        endcase
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // write-side state and status pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_cur_r    <= {PW{1'b0}};
      wr_ptr_commit_r <= {PW{1'b0}};
      wr_state_r      <= WR_NORMAL;
      overflow_r      <= 1'b0;
      bad_frame_r     <= 1'b0;
      good_frame_r    <= 1'b0;
    end else begin
      wr_ptr_cur_r    <= wr_ptr_cur_nxt_s;
      wr_ptr_commit_r <= wr_ptr_commit_nxt_s;
      wr_state_r      <= wr_state_nxt_s;
      overflow_r      <= overflow_nxt_s;
      bad_frame_r     <= bad_frame_nxt_s;
      good_frame_r    <= good_frame_nxt_s;
    end
  end

  // a new read may issue whenever the RAM read stage can move forward
  assign out_ready_s = !out_valid_r || m_axis.tready;
  assign rd_en_s     = !empty_s && (!rd_pend_r || out_ready_s);

  sdp_ram #(
    .WIDTH (BW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (wr_ptr_cur_r[AW-1:0]),
    .wr_data (wr_beat_s),
    .rd_en   (rd_en_s),
    .rd_addr (rd_ptr_r[AW-1:0]),
    .rd_data (rd_beat_s)
  );

  // read pointer, RAM-read-pending flag and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r    <= {PW{1'b0}};
      rd_pend_r   <= 1'b0;
      out_valid_r <= 1'b0;
      out_beat_r  <= {BW{1'b0}};
    end else begin
      rd_ptr_r <= rd_ptr_r + PW'(rd_en_s);
      if (rd_en_s) begin
        rd_pend_r <= 1'b1;
      end else if (out_ready_s) begin
        rd_pend_r <= 1'b0;
      end else begin
        rd_pend_r <= rd_pend_r;
      end
      if (out_ready_s) begin
        out_valid_r <= rd_pend_r;
        if (rd_pend_r) begin
          out_beat_r <= rd_beat_s;
        end else begin
          out_beat_r <= out_beat_r;
        end
      end else begin
        out_valid_r <= out_valid_r;
        out_beat_r  <= out_beat_r;
      end
    end
  end

  assign m_axis.tvalid  = out_valid_r;
  assign m_axis.twakeup = 1'b0;
  assign {m_axis.tdata, m_axis.tkeep, m_axis.tstrb, m_axis.tlast,
          m_axis.tid, m_axis.tdest, m_axis.tuser} = out_beat_r;

  assign status_occupancy  = wr_ptr_commit_r - rd_ptr_r;
  assign status_overflow   = overflow_r;
  assign status_bad_frame  = bad_frame_r;
  assign status_good_frame = good_frame_r;

endmodule

// File: tb/tb_axis_fifo.sv
// Directed bench: stream-mode instance (a) and frame-mode instance (b), both DEPTH=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_axis_fifo;

  logic       clk;
  logic       rst;
  logic [2:0] occ_a;
  logic       ovf_a, badf_a, good_a;
  logic [2:0] occ_b;
  logic       ovf_b, badf_b, good_b;
  int         total;
  int         bad;

  AXIS_IF #(.DATA_WIDTH(8), .ID_WIDTH(2), .DEST_WIDTH(2), .USER_WIDTH(1)) sa ();
  AXIS_IF #(.DATA_WIDTH(8), .ID_WIDTH(2), .DEST_WIDTH(2), .USER_WIDTH(1)) ma ();
  AXIS_IF #(.DATA_WIDTH(8), .ID_WIDTH(2), .DEST_WIDTH(2), .USER_WIDTH(1)) sb ();
  AXIS_IF #(.DATA_WIDTH(8), .ID_WIDTH(2), .DEST_WIDTH(2), .USER_WIDTH(1)) mb ();

  axis_fifo #(.DEPTH(4), .PACKET_MODE(1'b0), .DROP_BAD_FRAME(1'b0)) u_stream (
    .clk(clk), .rst(rst), .s_axis(sa), .m_axis(ma),
    .status_occupancy(occ_a), .status_overflow(ovf_a),
    .status_bad_frame(badf_a), .status_good_frame(good_a)
  );

  axis_fifo #(.DEPTH(4), .PACKET_MODE(1'b1), .DROP_BAD_FRAME(1'b1)) u_pkt (
    .clk(clk), .rst(rst), .s_axis(sb), .m_axis(mb),
    .status_occupancy(occ_b), .status_overflow(ovf_b),
    .status_bad_frame(badf_b), .status_good_frame(good_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [7:0] d, input logic l);
    sa.tvalid = v; sa.tdata = d; sa.tlast = l; sa.tkeep = 1'b1; sa.tstrb = 1'b1;
    sa.tid = 2'd1; sa.tdest = 2'd2; sa.tuser = 1'b0; sa.twakeup = 1'b0;
  endtask

  task automatic drive_b(input logic v, input logic [7:0] d, input logic l, input logic u);
    sb.tvalid = v; sb.tdata = d; sb.tlast = l; sb.tkeep = 1'b1; sb.tstrb = 1'b1;
    sb.tid = 2'd3; sb.tdest = 2'd1; sb.tuser = u; sb.twakeup = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (sa.tready !== 1'b0) begin bad++; $display("FAIL rst_s_tready_a actual=%0b required=0", sa.tready); end
    total++; if (sb.tready !== 1'b0) begin bad++; $display("FAIL rst_s_tready_b actual=%0b required=0", sb.tready); end
    total++; if (ma.tvalid !== 1'b0) begin bad++; $display("FAIL rst_m_tvalid_a actual=%0b required=0", ma.tvalid); end
    total++; if (mb.tvalid !== 1'b0) begin bad++; $display("FAIL rst_m_tvalid_b actual=%0b required=0", mb.tvalid); end
    total++; if (occ_a !== 3'd0) begin bad++; $display("FAIL rst_occ_a actual=%0d required=0", occ_a); end
    rst = 1'b0;
    #1;
    total++; if (sa.tready !== 1'b1) begin bad++; $display("FAIL post_rst_s_tready_a actual=%0b required=1", sa.tready); end
    total++; if (sb.tready !== 1'b1) begin bad++; $display("FAIL post_rst_s_tready_b actual=%0b required=1", sb.tready); end
    step();
  endtask

  task automatic test_latency();
    ma.tready = 1'b0;
    drive_a(1'b1, 8'hA5, 1'b1);
    step();
    drive_a(1'b0, 8'h00, 1'b0);
    total++; if (ma.tvalid !== 1'b0) begin bad++; $display("FAIL lat_n0 actual=%0b required=0", ma.tvalid); end
    total++; if (good_a !== 1'b0) begin bad++; $display("FAIL stream_good_pulse actual=%0b required=0", good_a); end
    step();
    total++; if (ma.tvalid !== 1'b0) begin bad++; $display("FAIL lat_n1 actual=%0b required=0", ma.tvalid); end
    step();
    total++; if (ma.tvalid !== 1'b1) begin bad++; $display("FAIL lat_n2_valid actual=%0b required=1", ma.tvalid); end
    total++; if ({ma.tdata, ma.tkeep, ma.tlast, ma.tid, ma.tdest} !== {8'hA5, 1'b1, 1'b1, 2'd1, 2'd2}) begin
      bad++; $display("FAIL lat_payload actual=%h/%b/%b required=a5/1/1", ma.tdata, ma.tkeep, ma.tlast);
    end
    ma.tready = 1'b1;
    step();
    total++; if (ma.tvalid !== 1'b0) begin bad++; $display("FAIL lat_drain actual=%0b required=0", ma.tvalid); end
    total++; if (occ_a !== 3'd0) begin bad++; $display("FAIL lat_occ actual=%0d required=0", occ_a); end
  endtask

  task automatic test_fill();
    logic [7:0] exp_d;
    ma.tready = 1'b0;
    // four beats fill the RAM; two more sit in the read stage and output register
    for (int i = 0; i < 6; i++) begin
      total++; if (sa.tready !== 1'b1) begin bad++; $display("FAIL fill_ready_%0d actual=%0b required=1", i, sa.tready); end
      exp_d = 8'h11 * 8'(i + 1);
      drive_a(1'b1, exp_d, 1'b0);
      step();
    end
    drive_a(1'b0, 8'h00, 1'b0);
    total++; if (sa.tready !== 1'b0) begin bad++; $display("FAIL full_ready actual=%0b required=0", sa.tready); end
    total++; if (occ_a !== 3'd4) begin bad++; $display("FAIL full_occ actual=%0d required=4", occ_a); end
    drive_a(1'b1, 8'h77, 1'b0);
    step();
    drive_a(1'b0, 8'h00, 1'b0);
    total++; if (occ_a !== 3'd4) begin bad++; $display("FAIL full_no_write actual=%0d required=4", occ_a); end
    ma.tready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      exp_d = 8'h11 * 8'(j + 1);
      total++; if (ma.tvalid !== 1'b1 || ma.tdata !== exp_d) begin
        bad++; $display("FAIL drain_%0d actual=%0b/%h required=1/%h", j, ma.tvalid, ma.tdata, exp_d);
      end
      step();
    end
    total++; if (ma.tvalid !== 1'b0) begin bad++; $display("FAIL drain_end actual=%0b required=0", ma.tvalid); end
    total++; if (sa.tready !== 1'b1) begin bad++; $display("FAIL drain_ready actual=%0b required=1", sa.tready); end
  endtask

  task automatic test_pkt_frame();
    mb.tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_b(1'b1, 8'hA1 + 8'(i), (i == 2), 1'b0);
      step();
      total++; if (mb.tvalid !== 1'b0) begin bad++; $display("FAIL pkt_hold_%0d actual=%0b required=0", i, mb.tvalid); end
    end
    drive_b(1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (good_b !== 1'b1) begin bad++; $display("FAIL pkt_good_pulse actual=%0b required=1", good_b); end
    step();
    total++; if (mb.tvalid !== 1'b0 || good_b !== 1'b0) begin
      bad++; $display("FAIL pkt_t1 actual=%0b/%0b required=0/0", mb.tvalid, good_b);
    end
    step();
    for (int j = 0; j < 3; j++) begin
      total++; if (mb.tvalid !== 1'b1 || mb.tdata !== 8'hA1 + 8'(j) || mb.tlast !== (j == 2)) begin
        bad++; $display("FAIL pkt_out_%0d actual=%0b/%h/%0b required=1/%h/%0b", j, mb.tvalid, mb.tdata, mb.tlast, 8'hA1 + 8'(j), (j == 2));
      end
      step();
    end
    total++; if (mb.tvalid !== 1'b0) begin bad++; $display("FAIL pkt_end actual=%0b required=0", mb.tvalid); end
  endtask

  task automatic test_overflow();
    int ovf_cnt;
    int good_cnt;
    int leak_cnt;
    ovf_cnt = 0; good_cnt = 0; leak_cnt = 0;
    mb.tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_b(1'b1, 8'hB1 + 8'(i), (i == 5), 1'b0);
      step();
      ovf_cnt  += int'(ovf_b);
      good_cnt += int'(good_b);
      leak_cnt += int'(mb.tvalid);
    end
    for (int i = 0; i < 2; i++) begin
      drive_b(1'b1, 8'hC1 + 8'(i), (i == 1), 1'b0);
      step();
      ovf_cnt  += int'(ovf_b);
      good_cnt += int'(good_b);
      leak_cnt += int'(mb.tvalid);
    end
    drive_b(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    total++; if (mb.tvalid !== 1'b0) begin bad++; $display("FAIL ovf_early actual=%0b required=0", mb.tvalid); end
    step();
    total++; if (mb.tvalid !== 1'b1 || mb.tdata !== 8'hC1) begin
      bad++; $display("FAIL ovf_second_0 actual=%0b/%h required=1/c1", mb.tvalid, mb.tdata);
    end
    step();
    total++; if (mb.tvalid !== 1'b1 || mb.tdata !== 8'hC2 || mb.tlast !== 1'b1) begin
      bad++; $display("FAIL ovf_second_1 actual=%0b/%h/%0b required=1/c2/1", mb.tvalid, mb.tdata, mb.tlast);
    end
    step();
    total++; if (mb.tvalid !== 1'b0) begin bad++; $display("FAIL ovf_end actual=%0b required=0", mb.tvalid); end
    total++; if (ovf_cnt !== 1) begin bad++; $display("FAIL ovf_pulses actual=%0d required=1", ovf_cnt); end
    total++; if (good_cnt !== 1) begin bad++; $display("FAIL ovf_good_pulses actual=%0d required=1", good_cnt); end
    total++; if (leak_cnt !== 0) begin bad++; $display("FAIL ovf_leak actual=%0d required=0", leak_cnt); end
  endtask

  task automatic test_bad_frame();
    mb.tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_b(1'b1, 8'hE1 + 8'(i), (i == 2), 1'b0);
      step();
    end
    drive_b(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) step();
    total++; if (occ_b !== 3'd1) begin bad++; $display("FAIL bad_prior_occ actual=%0d required=1", occ_b); end
    for (int i = 0; i < 3; i++) begin
      drive_b(1'b1, 8'hD1 + 8'(i), (i == 2), (i == 2));
      step();
    end
    drive_b(1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (badf_b !== 1'b1 || good_b !== 1'b0) begin
      bad++; $display("FAIL bad_pulse actual=%0b/%0b required=1/0", badf_b, good_b);
    end
    total++; if (occ_b !== 3'd1) begin bad++; $display("FAIL bad_occ actual=%0d required=1", occ_b); end
    step();
    total++; if (badf_b !== 1'b0) begin bad++; $display("FAIL bad_pulse_width actual=%0b required=0", badf_b); end
    mb.tready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      total++; if (mb.tvalid !== 1'b1 || mb.tdata !== 8'hE1 + 8'(j)) begin
        bad++; $display("FAIL bad_keep_%0d actual=%0b/%h required=1/%h", j, mb.tvalid, mb.tdata, 8'hE1 + 8'(j));
      end
      step();
    end
    step();
    total++; if (mb.tvalid !== 1'b0) begin bad++; $display("FAIL bad_no_output actual=%0b required=0", mb.tvalid); end
  endtask

  task automatic test_reset_midframe();
    mb.tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_b(1'b1, 8'h31 + 8'(i), (i == 2), 1'b0);
      step();
    end
    drive_b(1'b1, 8'h41, 1'b0, 1'b0);
    step();
    drive_b(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    total++; if (mb.tvalid !== 1'b1 || mb.tdata !== 8'h31 || occ_b !== 3'd1) begin
      bad++; $display("FAIL pre_rst actual=%0b/%h/%0d required=1/31/1", mb.tvalid, mb.tdata, occ_b);
    end
    #2;
    rst = 1'b1;
    #1;
    total++; if (mb.tvalid !== 1'b0) begin bad++; $display("FAIL async_rst_valid actual=%0b required=0", mb.tvalid); end
    total++; if (occ_b !== 3'd0) begin bad++; $display("FAIL async_rst_occ actual=%0d required=0", occ_b); end
    total++; if (sb.tready !== 1'b0) begin bad++; $display("FAIL async_rst_ready actual=%0b required=0", sb.tready); end
    step();
    rst = 1'b0;
    mb.tready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_b(1'b1, 8'h51 + 8'(i), (i == 1), 1'b0);
      step();
    end
    drive_b(1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (good_b !== 1'b1) begin bad++; $display("FAIL post_rst_good actual=%0b required=1", good_b); end
    step();
    step();
    for (int j = 0; j < 2; j++) begin
      total++; if (mb.tvalid !== 1'b1 || mb.tdata !== 8'h51 + 8'(j)) begin
        bad++; $display("FAIL post_rst_out_%0d actual=%0b/%h required=1/%h", j, mb.tvalid, mb.tdata, 8'h51 + 8'(j));
      end
      step();
    end
    total++; if (mb.tvalid !== 1'b0) begin bad++; $display("FAIL post_rst_end actual=%0b required=0", mb.tvalid); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive_a(1'b0, 8'h00, 1'b0);
    drive_b(1'b0, 8'h00, 1'b0, 1'b0);
    ma.tready = 1'b0;
    mb.tready = 1'b0;
    repeat (2) step();
    test_reset();
    test_latency();
    test_fill();
    test_pkt_frame();
    test_overflow();
    test_bad_frame();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
